univ_shift_deser: RTL
=====================

# univ_shift_deser

Serial-to-parallel receiver at the far end of the universal shift register's serial output. It captures one bit per clock from a serial line. The shift direction is selected by the same 2-bit `ctrl` encoding the shift register uses, so MSB-first (left-shift) and LSB-first (right-shift) streams are both reassembled. Each complete `DW`-bit word is presented on a parallel output with a one-cycle valid pulse, while a mid-frame direction change is flagged.

## Interface
- `DW`, 4, word width in bits; must be >= 2.
- `CW`, `$clog2(DW)`, width of the bit counter; derived, not overridden.

- `clk`  input  1  rising-edge clock.
- `sync_rst`  input  1  synchronous, active-high reset, sampled on the `clk` rising edge.
- `ctrl`  input  2  mode select:
  - 00: restart frame.
  - 01: capture LSB-first (shift right).
  - 10: capture MSB-first (shift left).
  - 11: hold.
- `sin`  input  1  serial data bit, sampled when `ctrl` is 01 or 10.
- `q`  output  DW  last completed word (registered).
- `q_valid`  output  1  one-cycle pulse; `q` updated this cycle.
- `busy`  output  1  partial frame in progress (`bit_cnt != 0`).
- `bit_cnt`  output  CW  bits captured in the current frame, 0..DW-1.
- `dir_err`  output  1  one-cycle pulse; capture direction changed mid-frame.

## Operation
- Internal state:
  - `sh[DW-1:0]`: assembly register.
  - `bit_cnt`: bit counter.
  - `dir`: frame direction, latched on the first bit of each frame.
  - `q`, `q_valid`, `dir_err`.
- ctrl=10 (MSB-first): `sh_next = {sh[DW-2:0], sin}`.
- ctrl=01 (LSB-first): `sh_next = {sin, sh[DW-1:1]}`.
- ctrl=11 (hold): `sh`, `bit_cnt`, `dir` and `q` unchanged; `q_valid` = 0; `dir_err` = 0.
- ctrl=00 (restart): `sh` = 0, `bit_cnt` = 0; `q` unchanged; no `q_valid`.
- First bit of a frame (`bit_cnt` == 0 during capture): `dir` latched from `ctrl`.
- Frame completion: a capture with `bit_cnt == DW-1` does all of the following on that edge:
  - `q` <= `sh_next`.
  - `q_valid` <= 1.
  - `bit_cnt` <= 0.
  - `sh` <= 0.
- Otherwise a capture sets `bit_cnt` <= `bit_cnt` + 1.
- Direction error: a capture with `bit_cnt != 0` and `ctrl` different from the latched `dir`:
  - `dir_err` <= 1 and the partial frame is discarded.
  - The current bit becomes bit 0 of a new frame: `sh` = shift of 0 with `sin` in the new direction, `bit_cnt` = 1, `dir` = new `ctrl`.
  - No `q_valid` pulse.
- Counter wrap: `bit_cnt` never reaches DW; it goes DW-1 -> 0 on completion only.
- Back-to-back frames: a capture on the cycle after completion is bit 0 of the next frame, with no gap.
- `busy` is combinational from `bit_cnt`: `busy = (bit_cnt != 0)`.

## Timing
- All state updates on the `clk` rising edge; no combinational path from `sin` or `ctrl` to any output except through registers (`busy` derives only from registered `bit_cnt`).
- Reset (`sync_rst` = 1 at an edge): `q` = 0, `q_valid` = 0, `dir_err` = 0, `bit_cnt` = 0, `busy` = 0, `sh` = 0, `dir` = MSB-first (10). Reset overrides `ctrl`. Reset mid-frame discards the partial word; `q` is cleared.
- Latency: the DW-th captured bit appears in `q` on the same edge that samples it; `q_valid` is high for exactly the following cycle.
- Throughput: one word every DW capture cycles; hold cycles stretch a frame without corrupting it.
- `q_valid` and `dir_err` are never high in the same cycle.
- `q` is stable between `q_valid` pulses; restart and hold never modify it.

## Test plan
- Reset: `sync_rst` = 1 for 2 edges with `ctrl` = 10 and `sin` = 1 -> `q` = 0000, `q_valid` = 0, `bit_cnt` = 0, `busy` = 0 afterwards.
- MSB-first frame: `ctrl` = 10, `sin` = 1,0,1,1 on 4 consecutive edges -> `bit_cnt` 1,2,3,0; `q` = 1011; `q_valid` high one cycle only. Then 8 more bits, 0110 followed by 1001, back-to-back -> two `q_valid` pulses exactly 4 cycles apart, `q` = 0110 then 1001.
- LSB-first frame: `ctrl` = 01, `sin` = 1,0,1,1 -> `q` = 1101, one `q_valid` pulse.
- Hold inside frame: `ctrl` = 10 with `sin` 1,1, then `ctrl` = 11 for 3 cycles with `sin` toggling, then `ctrl` = 10 with `sin` 0,0 -> `bit_cnt` holds 2 during the hold cycles, `busy` = 1; final `q` = 1100.
- Direction error: `ctrl` = 10 with `sin` 1,0, then `ctrl` = 01 with `sin` 1 -> `dir_err` pulse, no `q_valid`, `bit_cnt` = 1. Continue `ctrl` = 01 with `sin` 0,0,1 -> `q` = 1001.
- Restart and reset mid-frame: after a completed word 1011, capture 3 bits, then `ctrl` = 00 -> `bit_cnt` = 0, `q` stays 1011, no `q_valid`; the next full frame of bits 0,1,1,0 gives `q` = 0110. Repeat with `sync_rst` pulsed after 2 bits -> `q` = 0000, `bit_cnt` = 0.

Source files
------------

// File: rtl/univ_shift_deser_if.sv
// Bus bundle for the serial-to-parallel deserializer: serial/mode inputs and
// the parallel word, valid, and status outputs.
interface univ_shift_deser_if #(
  parameter int DW = 4
);
  localparam int CW = $clog2(DW);

  logic [1:0]    ctrl;
  logic          sin;
  logic [DW-1:0] q;
  logic          q_valid;
  logic          busy;
  logic [CW-1:0] bit_cnt;
  logic          dir_err;

  modport master (
    output ctrl, sin,
    input  q, q_valid, busy, bit_cnt, dir_err
  );

  modport slave (
    input  ctrl, sin,
    output q, q_valid, busy, bit_cnt, dir_err
  );
endinterface

// File: rtl/univ_shift_deser.sv
// Serial-to-parallel receiver: reassembles MSB-first or LSB-first DW-bit words
// from a serial line, pulses q_valid per word, and flags mid-frame direction changes.
module univ_shift_deser #(
  parameter int DW = 4
) (
  input  logic                clk,
  input  logic                sync_rst,
  univ_shift_deser_if.slave   bus
);
  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {
    MODE_RESTART = 2'b00,
    MODE_LSB     = 2'b01,
    MODE_MSB     = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_e;

  mode_e         mode;
  logic [DW-1:0] sh_q, sh_d, sh_shift;
  logic [CW-1:0] cnt_q, cnt_d;
  mode_e         dir_q, dir_d;
  logic [DW-1:0] q_q, q_d;
  logic          q_valid_q, q_valid_d;
  logic          dir_err_q, dir_err_d;

  function automatic logic [DW-1:0] shift_in(input logic [DW-1:0] cur,
                                             input logic          bit_in,
                                             input logic          msb_first);
    return msb_first ? {cur[DW-2:0], bit_in} : {bit_in, cur[DW-1:1]};
  endfunction

  assign mode = mode_e'(bus.ctrl);

  always_comb begin
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    q_d       = q_q;
    q_valid_d = 1'b0;
    dir_err_d = 1'b0;
    sh_shift  = '0;

    case (mode)
      MODE_RESTART: begin
        sh_d  = '0;
        cnt_d = '0;
      end
      MODE_LSB, MODE_MSB: begin
        if (cnt_q != '0 && mode != dir_q) begin
          // Direction flipped mid-frame: drop the partial word and restart with this bit.
          dir_err_d = 1'b1;
          sh_d      = shift_in('0, bus.sin, mode == MODE_MSB);
          cnt_d     = CW'(1);
          dir_d     = mode;
        end else begin
          if (cnt_q == '0) dir_d = mode;
          sh_shift = shift_in(sh_q, bus.sin, mode == MODE_MSB);
          if (cnt_q == CW'(DW - 1)) begin
            q_d       = sh_shift;
            q_valid_d = 1'b1;
            cnt_d     = '0;
            sh_d      = '0;
          end else begin
            sh_d  = sh_shift;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      sh_q      <= '0;
      cnt_q     <= '0;
      dir_q     <= MODE_MSB;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      dir_err_q <= 1'b0;
    end else begin
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      dir_err_q <= dir_err_d;
    end
  end

  assign bus.q       = q_q;
  assign bus.q_valid = q_valid_q;
  assign bus.bit_cnt = cnt_q;
  assign bus.busy    = (cnt_q != '0);
  assign bus.dir_err = dir_err_q;
endmodule
